au_cmp_eq_seq: RTL and testbench

- Sequential multi-chunk comparator for operands wider than a single datapath word.
- Consumes two unsigned operands streamed as NUM_CHUNKS chunks of WIDTH bits each, most-significant chunk first.
- Produces registered eq/lt/gt flags with a valid/ready output handshake.
- Sits downstream of the chunked operand fetch/serialiser and uses per-chunk equality internally.

---
 rtl/au_cmp_eq_seq.sv | 136 +++++++++++++
 tb/tb_au_cmp_eq_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/au_cmp_eq_seq.sv
// Sequential wide-operand comparator: A and B arrive as NUM_CHUNKS chunks, most-significant first.
// The first unequal chunk pair decides lt/gt; the eq/lt/gt result is presented with a valid/ready handshake.
module au_cmp_eq_seq #(
   parameter int WIDTH      = 8,
   parameter int NUM_CHUNKS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             decided_q, decided_d;
   logic             gt_r_q, gt_r_d;
   logic             lt_r_q, lt_r_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;
   logic             gt_q, gt_d;

   logic             accept;
   logic             gt_n, lt_n, decided_n;

   assign accept = in_valid & in_ready_q;

   // Relation after folding in the current chunk; an earlier decision always wins.
   always_comb begin
      gt_n      = gt_r_q;
      lt_n      = lt_r_q;
      decided_n = decided_q;
      if (!decided_q && (a != b)) begin
         gt_n      = (a > b);
         lt_n      = (a < b);
         decided_n = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      decided_d   = decided_q;
      gt_r_d      = gt_r_q;
      lt_r_d      = lt_r_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      eq_d        = eq_q;
      lt_d        = lt_q;
      gt_d        = gt_q;

      case (state_q)
         COLLECT: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            if (accept) begin
               if (cnt_q == LAST_IDX) begin
                  eq_d        = ~(gt_n | lt_n);
                  lt_d        = lt_n;
                  gt_d        = gt_n;
                  out_valid_d = 1'b1;
                  in_ready_d  = 1'b0;
                  state_d     = DONE;
                  cnt_d       = '0;
                  decided_d   = 1'b0;
                  gt_r_d      = 1'b0;
                  lt_r_d      = 1'b0;
               end else begin
                  cnt_d     = cnt_q + CNT_W'(1);
                  decided_d = decided_n;
                  gt_r_d    = gt_n;
                  lt_r_d    = lt_n;
               end
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = COLLECT;
            end
         end
         default: begin
            state_d     = COLLECT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         cnt_q       <= '0;
         decided_q   <= 1'b0;
         gt_r_q      <= 1'b0;
         lt_r_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         eq_q        <= 1'b0;
         lt_q        <= 1'b0;
         gt_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         decided_q   <= decided_d;
         gt_r_q      <= gt_r_d;
         lt_r_q      <= lt_r_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         eq_q        <= eq_d;
         lt_q        <= lt_d;
         gt_q        <= gt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign eq        = eq_q;
   assign lt        = lt_q;
   assign gt        = gt_q;

endmodule

// File: tb/tb_au_cmp_eq_seq.sv
// Bench for au_cmp_eq_seq: a 4-chunk and a 1-chunk instance with directed vectors.
// Expected {eq,lt,gt} results are queued at issue and popped by per-instance monitors on each handshake.
module tb_au_cmp_eq_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       v4 = 1'b0, or4 = 1'b1;
   logic [7:0] a4 = '0, b4 = '0;
   logic       rdy4, ov4, eq4, lt4, gt4;

   logic       v1 = 1'b0, or1 = 1'b1;
   logic [7:0] a1 = '0, b1 = '0;
   logic       rdy1, ov1, eq1, lt1, gt1;

   int checks = 0;
   int errors = 0;

   logic [2:0] q4[$];
   logic [2:0] q1[$];

   localparam logic [2:0] R_EQ = 3'b100;
   localparam logic [2:0] R_LT = 3'b010;
   localparam logic [2:0] R_GT = 3'b001;

   always #5 clk = ~clk;

   au_cmp_eq_seq #(.WIDTH(8), .NUM_CHUNKS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .a(a4), .b(b4),
      .out_valid(ov4), .out_ready(or4), .eq(eq4), .lt(lt4), .gt(gt4)
   );

   au_cmp_eq_seq #(.WIDTH(8), .NUM_CHUNKS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1),
      .out_valid(ov1), .out_ready(or1), .eq(eq1), .lt(lt1), .gt(gt1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: a result is consumed on every cycle with out_valid & out_ready.
   always @(negedge clk) begin
      logic [2:0] e;
      if (rst_n && ov4 && or4) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL mon4_unexpected: got {eq,lt,gt}=%b with no result pending", {eq4, lt4, gt4});
         end else begin
            e = q4.pop_front();
            if ({eq4, lt4, gt4} !== e) begin
               errors++;
               $display("FAIL mon4_result: got {eq,lt,gt}=%b expected %b at %0t", {eq4, lt4, gt4}, e, $time);
            end
         end
      end
      if (rst_n && ov1 && or1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL mon1_unexpected: got {eq,lt,gt}=%b with no result pending", {eq1, lt1, gt1});
         end else begin
            e = q1.pop_front();
            if ({eq1, lt1, gt1} !== e) begin
               errors++;
               $display("FAIL mon1_result: got {eq,lt,gt}=%b expected %b at %0t", {eq1, lt1, gt1}, e, $time);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic put4(input logic [7:0] ca, input logic [7:0] cb);
      int n = 0;
      a4 = ca; b4 = cb; v4 = 1'b1;
      while (!rdy4 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL put4_timeout: in_ready 0 expected 1");
      end
      @(posedge clk); #1;
      v4 = 1'b0; a4 = 8'hxx; b4 = 8'hxx;
   endtask

   task automatic put1(input logic [7:0] ca, input logic [7:0] cb);
      int n = 0;
      a1 = ca; b1 = cb; v1 = 1'b1;
      while (!rdy1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL put1_timeout: in_ready 0 expected 1");
      end
      @(posedge clk); #1;
      v1 = 1'b0; a1 = 8'hxx; b1 = 8'hxx;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic expect_done4(input string name, input logic [2:0] r);
      check({name, "_ov"}, ov4, 1'b1);
      check({name, "_flags"}, {eq4, lt4, gt4}, r);
      check({name, "_rdy"}, rdy4, 1'b0);
   endtask

   initial begin
      int n;
      #12;
      check("rst_rdy", rdy4, 1'b0);
      check("rst_ov", ov4, 1'b0);
      check("rst_flags", {eq4, lt4, gt4}, 3'b000);
      check("rst_ov1", ov1, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      check("rdy_before_edge", rdy4, 1'b0);
      @(posedge clk); #1;
      check("rdy_after_edge", rdy4, 1'b1);
      check("rdy1_after_edge", rdy1, 1'b1);

      // Test 1: all equal, consecutive
      put4(8'h12, 8'h12); put4(8'h34, 8'h34); put4(8'hAB, 8'hAB);
      q4.push_back(R_EQ);
      put4(8'hFF, 8'hFF);
      expect_done4("t1", R_EQ);
      idle(1);
      check("t1_back_ov", ov4, 1'b0);
      check("t1_back_rdy", rdy4, 1'b1);

      // Test 2: first chunk decides gt
      put4(8'h80, 8'h7F); put4(8'h00, 8'hFF); put4(8'h00, 8'hFF);
      q4.push_back(R_GT);
      put4(8'h00, 8'hFF);
      expect_done4("t2", R_GT);
      idle(1);

      // Test 3: last chunk decides lt
      put4(8'h55, 8'h55); put4(8'h55, 8'h55); put4(8'h55, 8'h55);
      q4.push_back(R_LT);
      put4(8'h01, 8'h02);
      expect_done4("t3", R_LT);
      idle(1);

      // Test 4: backpressure with in_valid held high
      or4 = 1'b0;
      put4(8'h10, 8'h10); put4(8'h20, 8'h21); put4(8'hFF, 8'h00);
      q4.push_back(R_LT);
      put4(8'hFF, 8'h00);
      expect_done4("t4_first", R_LT);
      v4 = 1'b1; a4 = 8'hF0; b4 = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         expect_done4("t4_hold", R_LT);
      end
      v4 = 1'b0; or4 = 1'b1;
      @(posedge clk); #1;
      check("t4_release_ov", ov4, 1'b0);
      check("t4_release_rdy", rdy4, 1'b1);
      put4(8'hC3, 8'hC3); put4(8'h01, 8'h01); put4(8'h9A, 8'h9A);
      q4.push_back(R_GT);
      put4(8'h02, 8'h01);
      expect_done4("t4_next", R_GT);
      idle(1);

      // Test 5: idle gaps between chunks of test 3
      put4(8'h55, 8'h55); idle(1);
      put4(8'h55, 8'h55); idle(3);
      put4(8'h55, 8'h55); idle(2);
      q4.push_back(R_LT);
      put4(8'h01, 8'h02);
      expect_done4("t5", R_LT);
      idle(1);

      // Test 6: async reset mid-operation
      put4(8'hFF, 8'h00); put4(8'h11, 8'h11);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_rdy", rdy4, 1'b0);
      check("t6_rst_ov", ov4, 1'b0);
      check("t6_rst_flags", {eq4, lt4, gt4}, 3'b000);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_rdy", rdy4, 1'b1);
      put4(8'h01, 8'h01); put4(8'h02, 8'h02); put4(8'h03, 8'h03);
      q4.push_back(R_EQ);
      put4(8'h04, 8'h04);
      expect_done4("t6_eq", R_EQ);

      // NUM_CHUNKS = 1
      q1.push_back(R_LT);
      put1(8'h03, 8'h09);
      check("t6_n1_ov", ov1, 1'b1);
      check("t6_n1_flags", {eq1, lt1, gt1}, R_LT);
      idle(1);
      q1.push_back(R_GT);
      put1(8'hA0, 8'h09);
      check("t6_n1_gt", {ov1, eq1, lt1, gt1}, {1'b1, R_GT});

      n = 0;
      while ((q4.size() != 0 || q1.size() != 0) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("pending_q4", q4.size(), 0);
      check("pending_q1", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
